// File: rtl/fake_dsp.sv
// Purpose : 4-deep sample window plus tap-serial FIR multiply-accumulate engine.
// Latency : window updates 1 cycle after en; result_o/done 1 cycle after the last-tap edge.
// Backpressure: none; the caller paces samples with en and taps with ce (gaps allowed).
//
// Ports:
//   clk, reset_n  - rising-edge clock, asynchronous active-low reset
//   en, signal    - sample strobe; signal[23:8] is shifted into signalWindow[0]
//   ce, tap,      - MAC enable, signed coefficient and its index for this cycle
//   tapnum
//   signalWindow  - window taps, [0] newest, [NTAPS-1] oldest
//   result_o      - signed filter output, held between completed passes
//   done          - one-cycle pulse when result_o is refreshed
module fake_dsp #(
  parameter int NTAPS = 4,
  parameter int DW    = 16,
  parameter int ACCW  = 34
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [24:0]                 signal,
  input  logic                        ce,
  input  logic signed [DW-1:0]        tap,
  input  logic [7:0]                  tapnum,
  output logic [NTAPS-1:0][DW-1:0]    signalWindow,
  output logic signed [ACCW-1:0]      result_o,
  output logic                        done
);

  localparam logic [7:0] LAST_TAP = 8'(NTAPS - 1);

  logic signed [DW-1:0]     sel;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   acc;
  logic signed [ACCW-1:0]   acc_next;

  // Only the top 16 bits of the 24-bit audio word are kept.
  logic unused_signal_bits;
  assign unused_signal_bits = ^{signal[24], signal[7:0]};

  // Sample window: shift toward older entries on each strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      signalWindow <= '0;
    end else if (en) begin
      signalWindow <= {signalWindow[NTAPS-2:0], signal[23:8]};
    end
  end

  // Tap select; an out-of-range tapnum selects zero so its product vanishes.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (tapnum == 8'(i)) sel = signed'(signalWindow[i]);
    end
  end

  assign prod     = tap * sel;
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  // Tap 0 opens a new pass, dropping whatever partial sum was left behind.
  assign acc_next = (tapnum == 8'd0) ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      result_o <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ce) begin
        acc <= acc_next;
        if (tapnum == LAST_TAP) begin
          result_o <= acc_next;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fake_dsp.sv
// Purpose : directed self-checking bench for fake_dsp (window, MAC, reset, gaps, restart).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: not applicable; the bench paces en/ce itself.
module tb_fake_dsp;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [24:0]      signal = '0;
  logic             ce = 1'b0;
  logic [15:0]      tap = '0;
  logic [7:0]       tapnum = '0;
  logic [3:0][15:0] signalWindow;
  logic [33:0]      result_o;
  logic             done;

  int vectors = 0;
  int miscompares = 0;

  fake_dsp dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .signal       (signal),
    .ce           (ce),
    .tap          (tap),
    .tapnum       (tapnum),
    .signalWindow (signalWindow),
    .result_o     (result_o),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push four samples oldest-first, so w0 ends up in signalWindow[0].
  task automatic load_window(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] vals [4];
    vals = '{w3, w2, w1, w0};
    ce = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      signal = {1'b0, vals[i], 8'h00};
      tick();
    end
    en = 1'b0;
  endtask

  task automatic do_tap(input logic [7:0] n, input logic [15:0] t);
    ce = 1'b1;
    tapnum = n;
    tap = t;
    tick();
    ce = 1'b0;
  endtask

  task automatic test_reset_initial();
    #3;
    vectors++;
    if (signalWindow !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_window got=%h exp=0", signalWindow);
    end
    vectors++;
    if (result_o !== 34'h0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_result got=%h done=%b exp=0/0", result_o, done);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_window();
    logic [23:0] seq [6];
    logic        ens [6];
    seq = '{24'h111111, 24'h000000, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    ens = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      en = ens[i];
      signal = {1'b1, seq[i]};  // bit 24 set to show it is ignored
      tick();
      if (i < 2) begin
        vectors++;
        if (signalWindow !== {16'h0, 16'h0, 16'h0, 16'h1111}) begin
          miscompares++;
          $display("FAIL window_step%0d got=%h exp=%h", i, signalWindow,
                   {16'h0, 16'h0, 16'h0, 16'h1111});
        end
      end
    end
    en = 1'b0;
    vectors++;
    if (signalWindow !== {16'h2222, 16'h3333, 16'h4444, 16'h5555}) begin
      miscompares++;
      $display("FAIL window_final got=%h exp=%h", signalWindow,
               {16'h2222, 16'h3333, 16'h4444, 16'h5555});
    end
  endtask

  task automatic test_mac();
    load_window(16'd1, 16'd2, 16'd3, 16'd4);
    do_tap(8'd0, 16'd4);
    do_tap(8'd1, 16'd1);
    do_tap(8'd2, 16'd2);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mac_done_early got=%b exp=0", done);
    end
    do_tap(8'd3, 16'd1);
    vectors++;
    if (result_o !== 34'd16 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL mac_result got=%h done=%b exp=%h/1", result_o, done, 34'd16);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || result_o !== 34'd16) begin
      miscompares++;
      $display("FAIL mac_done_pulse got=%b result=%h exp=0/%h", done, result_o, 34'd16);
    end
  endtask

  task automatic test_reset_midpass();
    do_tap(8'd0, 16'd4);
    do_tap(8'd1, 16'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (signalWindow !== 64'h0 || result_o !== 34'h0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got win=%h res=%h done=%b exp=0/0/0",
               signalWindow, result_o, done);
    end
    #3;
    reset_n = 1'b1;
    // Pass without tap 0: a cleared accumulator gives 2+6+4 = 12.
    load_window(16'd1, 16'd2, 16'd3, 16'd4);
    do_tap(8'd1, 16'd1);
    do_tap(8'd2, 16'd2);
    do_tap(8'd3, 16'd1);
    vectors++;
    if (result_o !== 34'd12 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_clears_acc got=%h done=%b exp=%h/1", result_o, done, 34'd12);
    end
  endtask

  task automatic test_ce_gap();
    load_window(16'd1, 16'd2, 16'd3, 16'd4);
    do_tap(8'd0, 16'd4);
    do_tap(8'd1, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tapnum = 8'd3;  // must be ignored while ce is low
      tick();
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_done%0d got=%b exp=0", i, done);
      end
    end
    do_tap(8'd2, 16'd2);
    do_tap(8'd3, 16'd1);
    vectors++;
    if (result_o !== 34'd16 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_result got=%h done=%b exp=%h/1", result_o, done, 34'd16);
    end
  endtask

  task automatic test_fullscale();
    load_window(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    for (int i = 0; i < 4; i++) do_tap(8'(i), 16'h8000);
    vectors++;
    if (result_o !== 34'h1_0000_0000 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL fullscale_neg_neg got=%h done=%b exp=%h/1", result_o, done, 34'h1_0000_0000);
    end
    for (int i = 0; i < 4; i++) do_tap(8'(i), 16'h7FFF);
    // -4 * 0x3FFF8000 = -0xFFFE0000, i.e. 0x3_0002_0000 in 34 bits
    vectors++;
    if (result_o !== 34'h3_0002_0000) begin
      miscompares++;
      $display("FAIL fullscale_pos_neg got=%h exp=%h", result_o, 34'h3_0002_0000);
    end
  endtask

  task automatic test_restart();
    load_window(16'd1, 16'd2, 16'd3, 16'd4);
    do_tap(8'd0, 16'd100);
    do_tap(8'd1, 16'd100);
    do_tap(8'd0, 16'd4);
    do_tap(8'd1, 16'd1);
    do_tap(8'd2, 16'd2);
    do_tap(8'd3, 16'd1);
    vectors++;
    if (result_o !== 34'd16 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_result got=%h done=%b exp=%h/1", result_o, done, 34'd16);
    end
  endtask

  task automatic test_out_of_range();
    do_tap(8'd0, 16'd4);
    do_tap(8'd1, 16'd1);
    do_tap(8'd2, 16'd2);
    do_tap(8'd3, 16'd1);
    do_tap(8'd7, 16'h7FFF);
    vectors++;
    if (done !== 1'b0 || result_o !== 34'd16) begin
      miscompares++;
      $display("FAIL oor_hold got done=%b res=%h exp=0/%h", done, result_o, 34'd16);
    end
    do_tap(8'd3, 16'd1);
    vectors++;
    if (result_o !== 34'd20 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_zero_prod got=%h done=%b exp=%h/1", result_o, done, 34'd20);
    end
  endtask

  task automatic test_back_to_back();
    // Repeated last tap publishes every cycle: 20 -> 24 -> 28.
    ce = 1'b1;
    tapnum = 8'd3;
    tap = 16'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (done !== 1'b1 || result_o !== 34'(24 + 4 * i)) begin
        miscompares++;
        $display("FAIL b2b_%0d got=%h done=%b exp=%h/1", i, result_o, done, 34'(24 + 4 * i));
      end
    end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_en_ce_same_edge();
    load_window(16'd1, 16'd2, 16'd3, 16'd4);
    // tap 0 must see the pre-shift sample (1), not the one shifted in (9).
    en = 1'b1;
    signal = {1'b0, 16'd9, 8'h00};
    do_tap(8'd0, 16'd5);
    en = 1'b0;
    do_tap(8'd3, 16'd0);
    vectors++;
    if (result_o !== 34'd5 || signalWindow[0] !== 16'd9) begin
      miscompares++;
      $display("FAIL en_ce_same_edge got res=%h w0=%h exp=%h/%h",
               result_o, signalWindow[0], 34'd5, 16'd9);
    end
  endtask

  initial begin
    test_reset_initial();
    test_window();
    test_mac();
    test_reset_midpass();
    test_ce_gap();
    test_fullscale();
    test_restart();
    test_out_of_range();
    test_back_to_back();
    test_en_ce_same_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fake_dsp.md
# fake_dsp

Fixed-length FIR datapath for the audio filter path: a sample window shift register (`signalwindow` function) keeps the four most recent 16-bit samples. A tap-serial multiply-accumulate engine (`fakedsp` function) forms one filter output per pass over the taps. It sits between the audio sample source and the output formatter, and runs one tap per enabled clock.

## Interface
- `NTAPS`, 4: number of taps, equal to the window depth.
- `DW`, 16: sample and coefficient width, signed two's complement.
- `ACCW`, 34: accumulator and result width, 2·DW + log2(NTAPS).

Ports:
- `clk`  in  1  single rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; shifts `signal` into the window.
- `signal`  in  25  incoming sample; `signal[23:8]` (top 16 bits of the 24-bit audio word) is stored.
- `ce`  in  1  MAC clock enable; one tap is processed per enabled cycle.
- `tap`  in  DW  coefficient for the current tap, signed.
- `tapnum`  in  8  index of the current tap, 0..NTAPS-1.
- `signalWindow`  out  NTAPS×DW  window taps; [0] is newest and [NTAPS-1] is oldest.
- `result_o`  out  ACCW  filter output, signed, held until the next completed pass.
- `done`  out  1  single-cycle pulse when `result_o` is updated.

## Operation
- Window:
  - With `en`=1 at a rising edge: `signalWindow[0]` ← `signal[23:8]`, and `signalWindow[i]` ← `signalWindow[i-1]` for i = 1..NTAPS-1.
  - With `en`=0: all entries hold.
  - `signal[24]` is ignored.
- MAC, on a rising edge with `ce`=1:
  - `prod` = `tap` × `signalWindow[tapnum]`, signed 2·DW bits, sign-extended to ACCW.
  - If `tapnum`==0, `acc` ← `prod`; a new pass starts and any previous partial sum is discarded.
  - Otherwise `acc` ← `acc` + `prod`.
  - If `tapnum`==NTAPS-1, also `result_o` ← `acc` + `prod` and `done` ← 1.
- With `ce`=0: `acc` and `result_o` hold; `done` ← 0.
- `tapnum` ≥ NTAPS: the product is treated as 0 and `done` is not raised.
- Taps need not be contiguous in time. `ce` gaps are allowed mid-pass and the pass resumes with the next `tapnum`.
- Out-of-order `tapnum` values are accumulated as given. Only `tapnum`==0 clears the accumulator and only `tapnum`==NTAPS-1 publishes.
- Arithmetic: no saturation or rounding. ACCW is sized so NTAPS full-scale products cannot overflow.

## Timing
- Reset (asynchronous, `reset_n`=0): all `signalWindow` entries = 0, `acc` = 0, `result_o` = 0, `done` = 0. Reset mid-pass discards the partial sum.
- Window latency: 1 cycle from the `en` edge to the new value on `signalWindow[0]`.
- MAC latency: `result_o` and `done` are valid 1 cycle after the edge that sampled `tapnum`==NTAPS-1. A pass takes at least NTAPS enabled cycles.
- `done` is high for exactly one cycle per completed pass. It can be high on consecutive cycles if `tapnum`==NTAPS-1 is presented repeatedly.
- Simultaneous `en` and `ce` on the same edge: the MAC uses the pre-shift window contents, because the window registers update on the same edge. Keeping the window stable for a whole pass is the caller's responsibility.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `reset_n`=0 mid-operation → `signalWindow` = {0,0,0,0}, `result_o` = 0, `done` = 0 immediately, independent of `clk`.
- Window fill: apply `en`=1 with `signal`=0x111111, then `en`=0 with 0x000000, then `en`=1 with 0x222222, 0x333333, 0x444444, 0x555555.
  - After the first edge, `signalWindow[0]` = 0x1111.
  - The `en`=0 cycle leaves the window unchanged.
  - Final window = {0x5555, 0x4444, 0x3333, 0x2222}.
- MAC pass: window = {1,2,3,4}, `ce`=1, (`tapnum`,`tap`) = (0,4), (1,1), (2,2), (3,1) on consecutive cycles → `result_o` = 16 (0x10), with `done` high for one cycle after the 4th edge.
- Signed/full-scale: window all 0x8000, all taps 0x8000 → `result_o` = 4·2^30 = 0x1_0000_0000 with no overflow. Taps 0x7FFF against window 0x8000 → `result_o` = −4·0x3FFF8000.
- `ce` gap: insert `ce`=0 cycles between taps 1 and 2 of the MAC-pass vector → same result 16, `done` only after tap 3, and `done`=0 during the gaps.
- Restart: abandon a pass after tap 1, then run a full pass → the result equals the full-pass value only, with no stale partial sum.
